// File: rtl/wb_stage_pkg.sv
// Shared widths and load-size encodings for the writeback stage.
// The macro block mirrors rvseed_defines.v; new encodings belong there first.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_DEPTH
`define REG_DATA_DEPTH 32
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef LSIZE_B
`define LSIZE_B 2'd0
`define LSIZE_H 2'd1
`define LSIZE_W 2'd2
`define LSIZE_D 2'd3
`endif

package wb_stage_pkg;
  localparam int REG_AW    = `REG_ADDR_WIDTH;
  localparam int REG_DEPTH = `REG_DATA_DEPTH;
  localparam int CPU_W     = `CPU_WIDTH;

  typedef enum logic [1:0] {
    LS_B = `LSIZE_B,
    LS_H = `LSIZE_H,
    LS_W = `LSIZE_W,
    LS_D = `LSIZE_D
  } lsize_e;
endpackage

// File: rtl/wb_load_ext.sv
// Commit-value select: ALU result, or shifted/truncated/extended load data.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            load,
  input  logic [1:0]      lsize,
  input  logic            lunsigned,
  input  logic [2:0]      loff,
  input  logic [XLEN-1:0] mdata,
  input  logic [XLEN-1:0] alu,
  output logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] sh;

  // Misaligned accesses simply see the zero-filled upper bits of the shift.
  assign sh = mdata >> {loff, 3'b000};

  always_comb begin
    wdata = alu;
    if (load) begin
      case (lsize_e'(lsize))
        LS_B:    wdata = lunsigned ? XLEN'(sh[7:0])  : {{(XLEN-8){sh[7]}},   sh[7:0]};
        LS_H:    wdata = lunsigned ? XLEN'(sh[15:0]) : {{(XLEN-16){sh[15]}}, sh[15:0]};
        LS_W:    wdata = lunsigned ? XLEN'(sh[31:0]) : {{(XLEN-32){sh[31]}}, sh[31:0]};
        default: wdata = sh;
      endcase
    end
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: request FIFO draining one commit per cycle into the
// register file, plus a per-register pending-write scoreboard.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_wen,
  input  logic [REG_AW-1:0]               in_waddr,
  input  logic [XLEN-1:0]                 in_alu,
  input  logic                            in_load,
  input  logic [1:0]                      in_lsize,
  input  logic                            in_lunsigned,
  input  logic [2:0]                      in_loff,
  input  logic [XLEN-1:0]                 in_mdata,
  input  logic                            issue_valid,
  input  logic [REG_AW-1:0]               issue_waddr,
  output logic                            issue_ready,
  output logic [REG_DEPTH-1:0][XLEN-1:0]  reg_f,
  output logic [REG_AW-1:0]               wb_reg_waddr,
  output logic                            write_ready,
  output logic [REG_DEPTH-1:0]            busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  wb_req_t         fifo_q [FIFO_DEPTH];
  wb_req_t         req_d, head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] ext_data;
  logic            push, pop, commit, issue_fire;
  logic [REG_DEPTH-1:0][1:0] cnt_vec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  wb_load_ext #(.XLEN(XLEN)) u_ext (
    .load(in_load), .lsize(in_lsize), .lunsigned(in_lunsigned),
    .loff(in_loff), .mdata(in_mdata), .alu(in_alu), .wdata(ext_data)
  );

  // Load data is resolved at acceptance so the FIFO only holds the commit value.
  assign req_d    = '{wen: in_wen, waddr: in_waddr, data: ext_data};
  assign in_ready = (count != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0);
  assign head     = fifo_q[rd_ptr];
  assign commit   = pop && head.wen && (head.waddr != '0);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      write_ready  <= 1'b0;
      wb_reg_waddr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count       <= count + CW'(push) - CW'(pop);
      write_ready <= commit;
      if (commit) wb_reg_waddr <= head.waddr;
    end
  end

  // A full counter still accepts an issue when a commit frees a slot that edge.
  assign issue_ready = !((cnt_vec[issue_waddr] == 2'd3) &&
                         !(commit && head.waddr == issue_waddr));
  assign issue_fire  = issue_valid && issue_ready && (issue_waddr != '0);

  for (genvar i = 0; i < REG_DEPTH; i++) begin : g_reg
    if (i == 0) begin : g_x0
      assign reg_f[i]   = '0;
      assign busy[i]    = 1'b0;
      assign cnt_vec[i] = 2'd0;
    end else begin : g_rn
      logic [XLEN-1:0] rf_q;
      logic [1:0]      cnt;
      logic            inc, hit;

      assign inc = issue_fire && (issue_waddr == REG_AW'(i));
      assign hit = commit && (head.waddr == REG_AW'(i));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rf_q <= '0;
          cnt  <= 2'd0;
        end else begin
          if (hit) rf_q <= head.data;
          if (inc && !hit)                      cnt <= cnt + 2'd1;
          else if (hit && !inc && cnt != 2'd0)  cnt <= cnt - 2'd1;
        end
      end

      assign reg_f[i]   = rf_q;
      assign busy[i]    = (cnt != 2'd0);
      assign cnt_vec[i] = cnt;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: default-depth instance plus a depth-1 instance
// whose FIFO can actually fill, since a per-cycle drain never queues two entries.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_valid1, in_wen, in_load, in_lunsigned;
  logic [REG_AW-1:0] in_waddr, issue_waddr;
  logic [63:0] in_alu, in_mdata;
  logic [1:0]  in_lsize;
  logic [2:0]  in_loff;
  logic        issue_valid;

  logic in_ready, issue_ready, write_ready;
  logic [REG_AW-1:0] wb_reg_waddr;
  logic [REG_DEPTH-1:0][63:0] reg_f;
  logic [REG_DEPTH-1:0] busy;

  logic in_ready1, issue_ready1, write_ready1;
  logic [REG_AW-1:0] wb_reg_waddr1;
  logic [REG_DEPTH-1:0][63:0] reg_f1;
  logic [REG_DEPTH-1:0] busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(64), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_alu(in_alu), .in_load(in_load),
    .in_lsize(in_lsize), .in_lunsigned(in_lunsigned), .in_loff(in_loff),
    .in_mdata(in_mdata), .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .issue_ready(issue_ready), .reg_f(reg_f), .wb_reg_waddr(wb_reg_waddr),
    .write_ready(write_ready), .busy(busy)
  );

  wb_stage #(.XLEN(64), .FIFO_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_alu(in_alu), .in_load(in_load),
    .in_lsize(in_lsize), .in_lunsigned(in_lunsigned), .in_loff(in_loff),
    .in_mdata(in_mdata), .issue_valid(1'b0), .issue_waddr(issue_waddr),
    .issue_ready(issue_ready1), .reg_f(reg_f1), .wb_reg_waddr(wb_reg_waddr1),
    .write_ready(write_ready1), .busy(busy1)
  );

  task automatic set_req(input logic wen, input logic [4:0] a, input logic [63:0] alu,
                         input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [2:0] off, input logic [63:0] md);
    in_wen = wen; in_waddr = a; in_alu = alu; in_load = ld;
    in_lsize = sz; in_lunsigned = uns; in_loff = off; in_mdata = md;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (reg_f !== '0) begin n_bad++; $display("FAIL rst_regf: reg_f not zero (r1=%h)", reg_f[1]); end
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL rst_busy: got %h want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready); end
    n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL rst_write_ready: got %b want 0", write_ready); end
    n_cmp++; if (wb_reg_waddr !== 5'd0) begin n_bad++; $display("FAIL rst_wb_waddr: got %0d want 0", wb_reg_waddr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu;
    set_req(1, 5, 64'h1234, 0, 0, 0, 0, 64'h0); in_valid = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_in_ready: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (reg_f[5] !== 64'h0) begin n_bad++; $display("FAIL alu_early: got %h want 0", reg_f[5]); end
    @(negedge clk);
    n_cmp++; if (reg_f[5] !== 64'h1234) begin n_bad++; $display("FAIL alu_data: got %h want 1234", reg_f[5]); end
    n_cmp++; if (write_ready !== 1'b1) begin n_bad++; $display("FAIL alu_wr: got %b want 1", write_ready); end
    n_cmp++; if (wb_reg_waddr !== 5'd5) begin n_bad++; $display("FAIL alu_waddr: got %0d want 5", wb_reg_waddr); end
    @(negedge clk);
    n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL alu_wr_drop: got %b want 0", write_ready); end
    n_cmp++; if (wb_reg_waddr !== 5'd5) begin n_bad++; $display("FAIL alu_waddr_hold: got %0d want 5", wb_reg_waddr); end
  endtask

  task automatic test_load;
    set_req(1, 10, 64'h0, 1, 1, 0, 6, 64'h80FF_0000_0000_0000); in_valid = 1'b1;
    @(negedge clk); set_req(1, 11, 64'h0, 1, 1, 1, 6, 64'h80FF_0000_0000_0000);
    @(negedge clk); set_req(1, 12, 64'h0, 1, 2, 0, 6, 64'h1122_3344_5566_7788);
    n_cmp++; if (reg_f[10] !== 64'hFFFF_FFFF_FFFF_80FF) begin n_bad++; $display("FAIL ld_h_signed: got %h want ffffffffffff80ff", reg_f[10]); end
    @(negedge clk); set_req(1, 13, 64'h0, 1, 0, 0, 0, 64'h1122_3344_5566_7788);
    n_cmp++; if (reg_f[11] !== 64'h80FF) begin n_bad++; $display("FAIL ld_h_unsigned: got %h want 80ff", reg_f[11]); end
    @(negedge clk); set_req(1, 14, 64'h0, 1, 3, 1, 0, 64'h1122_3344_5566_7788);
    n_cmp++; if (reg_f[12] !== 64'h1122) begin n_bad++; $display("FAIL ld_w_misaligned: got %h want 1122", reg_f[12]); end
    @(negedge clk); set_req(1, 15, 64'h0, 1, 3, 0, 4, 64'h1122_3344_5566_7788);
    n_cmp++; if (reg_f[13] !== 64'hFFFF_FFFF_FFFF_FF88) begin n_bad++; $display("FAIL ld_b_signed: got %h want ffffffffffffff88", reg_f[13]); end
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (reg_f[14] !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL ld_d: got %h want 1122334455667788", reg_f[14]); end
    @(negedge clk);
    n_cmp++; if (reg_f[15] !== 64'h1122_3344) begin n_bad++; $display("FAIL ld_d_misaligned: got %h want 11223344", reg_f[15]); end
    n_cmp++; if (wb_reg_waddr !== 5'd15) begin n_bad++; $display("FAIL ld_waddr: got %0d want 15", wb_reg_waddr); end
  endtask

  task automatic test_x0;
    set_req(1, 0, 64'hDEAD, 0, 0, 0, 0, 64'h0); in_valid = 1'b1;
    @(negedge clk); set_req(0, 3, 64'hBEEF, 1, 3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL x0_wr: got %b want 0", write_ready); end
    n_cmp++; if (reg_f[0] !== 64'h0) begin n_bad++; $display("FAIL x0_data: got %h want 0", reg_f[0]); end
    n_cmp++; if (wb_reg_waddr !== 5'd15) begin n_bad++; $display("FAIL x0_waddr_hold: got %0d want 15", wb_reg_waddr); end
    @(negedge clk);
    n_cmp++; if (write_ready !== 1'b0) begin n_bad++; $display("FAIL nowen_wr: got %b want 0", write_ready); end
    n_cmp++; if (reg_f[3] !== 64'h0) begin n_bad++; $display("FAIL nowen_data: got %h want 0", reg_f[3]); end
  endtask

  // Default depth: the queue drains every edge, so in_ready stays high throughout.
  task automatic test_back_to_back;
    set_req(1, 20, 64'hA1, 0, 0, 0, 0, 64'h0); in_valid = 1'b1;
    @(negedge clk); set_req(1, 21, 64'hA2, 0, 0, 0, 0, 64'h0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready2: got %b want 1", in_ready); end
    @(negedge clk); set_req(1, 22, 64'hA3, 0, 0, 0, 0, 64'h0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready3: got %b want 1", in_ready); end
    n_cmp++; if (write_ready !== 1'b1 || wb_reg_waddr !== 5'd20) begin n_bad++; $display("FAIL b2b_c1: got %b/%0d want 1/20", write_ready, wb_reg_waddr); end
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (write_ready !== 1'b1 || wb_reg_waddr !== 5'd21) begin n_bad++; $display("FAIL b2b_c2: got %b/%0d want 1/21", write_ready, wb_reg_waddr); end
    @(negedge clk);
    n_cmp++; if (write_ready !== 1'b1 || wb_reg_waddr !== 5'd22) begin n_bad++; $display("FAIL b2b_c3: got %b/%0d want 1/22", write_ready, wb_reg_waddr); end
    n_cmp++; if (reg_f[20] !== 64'hA1 || reg_f[21] !== 64'hA2 || reg_f[22] !== 64'hA3) begin n_bad++; $display("FAIL b2b_data: got %h %h %h want a1 a2 a3", reg_f[20], reg_f[21], reg_f[22]); end
  endtask

  task automatic test_backpressure;
    set_req(1, 24, 64'h11, 0, 0, 0, 0, 64'h0); in_valid1 = 1'b1; #1;
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a: got %b want 1", in_ready1); end
    @(negedge clk); set_req(1, 25, 64'h22, 0, 0, 0, 0, 64'h0);
    n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL bp_full_b: got %b want 0", in_ready1); end
    @(negedge clk);
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL bp_drain_a: got %b want 1", in_ready1); end
    n_cmp++; if (write_ready1 !== 1'b1 || wb_reg_waddr1 !== 5'd24 || reg_f1[24] !== 64'h11) begin n_bad++; $display("FAIL bp_commit_a: got %b/%0d/%h want 1/24/11", write_ready1, wb_reg_waddr1, reg_f1[24]); end
    @(negedge clk); set_req(1, 26, 64'h33, 0, 0, 0, 0, 64'h0);
    n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL bp_full_c: got %b want 0", in_ready1); end
    @(negedge clk);
    n_cmp++; if (reg_f1[25] !== 64'h22 || wb_reg_waddr1 !== 5'd25) begin n_bad++; $display("FAIL bp_commit_b: got %h/%0d want 22/25", reg_f1[25], wb_reg_waddr1); end
    @(negedge clk); in_valid1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (reg_f1[26] !== 64'h33 || write_ready1 !== 1'b1 || wb_reg_waddr1 !== 5'd26) begin n_bad++; $display("FAIL bp_commit_c: got %h/%b/%0d want 33/1/26", reg_f1[26], write_ready1, wb_reg_waddr1); end
  endtask

  task automatic test_scoreboard;
    issue_waddr = 5'd7; issue_valid = 1'b1; #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL sb_ready0: got %b want 1", issue_ready); end
    repeat (3) @(negedge clk);
    issue_valid = 1'b0; #1;
    n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL sb_busy3: got %b want 1", busy[7]); end
    n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL sb_sat: got %b want 0", issue_ready); end
    issue_waddr = 5'd8; #1;
    n_cmp++; if (issue_ready !== 1'b1 || busy[8] !== 1'b0) begin n_bad++; $display("FAIL sb_other: got %b/%b want 1/0", issue_ready, busy[8]); end
    set_req(1, 7, 64'h77, 0, 0, 0, 0, 64'h0); in_valid = 1'b1; issue_waddr = 5'd7;
    @(negedge clk); in_valid = 1'b0; #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL sb_bypass: got %b want 1", issue_ready); end
    issue_valid = 1'b1;
    @(negedge clk); issue_valid = 1'b0; #1;
    n_cmp++; if (busy[7] !== 1'b1 || issue_ready !== 1'b0) begin n_bad++; $display("FAIL sb_same_edge: got %b/%b want 1/0", busy[7], issue_ready); end
    n_cmp++; if (reg_f[7] !== 64'h77) begin n_bad++; $display("FAIL sb_data: got %h want 77", reg_f[7]); end
    set_req(1, 7, 64'h1, 0, 0, 0, 0, 64'h0); in_valid = 1'b1;
    @(negedge clk); set_req(1, 7, 64'h2, 0, 0, 0, 0, 64'h0);
    @(negedge clk); set_req(1, 7, 64'h3, 0, 0, 0, 0, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL sb_two_commits: got %b want 1", busy[7]); end
    @(negedge clk);
    n_cmp++; if (busy[7] !== 1'b0 || reg_f[7] !== 64'h3) begin n_bad++; $display("FAIL sb_drained: got %b/%h want 0/3", busy[7], reg_f[7]); end
    set_req(1, 7, 64'h4, 0, 0, 0, 0, 64'h0); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy[7] !== 1'b0 || reg_f[7] !== 64'h4) begin n_bad++; $display("FAIL sb_commit_at_zero: got %b/%h want 0/4", busy[7], reg_f[7]); end
  endtask

  task automatic test_reset_mid;
    issue_waddr = 5'd9; issue_valid = 1'b1;
    set_req(1, 30, 64'hAA, 0, 0, 0, 0, 64'h0); in_valid = 1'b1;
    @(negedge clk); issue_valid = 1'b0; set_req(1, 31, 64'hBB, 0, 0, 0, 0, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (busy[9] !== 1'b1 || reg_f[30] !== 64'hAA) begin n_bad++; $display("FAIL rm_pre: got %b/%h want 1/aa", busy[9], reg_f[30]); end
    rst_n = 1'b0; #1;
    n_cmp++; if (reg_f !== '0) begin n_bad++; $display("FAIL rm_regf: reg_f not zero (r30=%h)", reg_f[30]); end
    n_cmp++; if (busy !== '0 || write_ready !== 1'b0 || wb_reg_waddr !== 5'd0) begin n_bad++; $display("FAIL rm_state: got busy=%h wr=%b wa=%0d want 0/0/0", busy, write_ready, wb_reg_waddr); end
    n_cmp++; if (in_ready !== 1'b1 || issue_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %b/%b want 1/1", in_ready, issue_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (write_ready !== 1'b0 || reg_f[31] !== 64'h0) begin n_bad++; $display("FAIL rm_release: got %b/%h want 0/0", write_ready, reg_f[31]); end
    @(negedge clk);
    n_cmp++; if (write_ready !== 1'b0 || reg_f !== '0 || busy !== '0) begin n_bad++; $display("FAIL rm_after: got wr=%b busy=%h r31=%h want 0/0/0", write_ready, busy, reg_f[31]); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; issue_valid = 1'b0; issue_waddr = '0;
    set_req(0, 0, 64'h0, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    test_reset;
    test_alu;
    test_load;
    test_x0;
    test_back_to_back;
    test_backpressure;
    test_scoreboard;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
